// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package wrr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Widest weight field the clamp helper accepts; callers cast to/from it.
  localparam int WMAX = 16;

  function automatic logic [WMAX-1:0] clamp_weight(input logic [WMAX-1:0] w);
    logic [WMAX-1:0] r;
    if (w == {WMAX{1'b0}}) begin
      r = {{(WMAX-1){1'b0}}, 1'b1};
    end else begin
      r = w;
    end
    return r;
  endfunction

endpackage

// File: rtl/wrr_burst_arb_rr_pick.sv
// Combinational rotate-priority pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    any,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  // Scan from the farthest offset down so the closest request to ptr wins.
  always_comb begin
    int c;
    c   = 0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NREQ;
      if (req[c]) begin
        any = 1'b1;
        idx = IW'(c);
      end else begin
        any = any;
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arb.sv
// Weighted round-robin arbiter: a grantee keeps the resource for up to its
// weight in acknowledged beats, then one idle cycle precedes the next pick.
module wrr_burst_arb
  import wrr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WWID = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WWID-1:0]    weight_i,
  input  logic                    ack_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    gnt_vld_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0]   LAST_IDX   = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT    = NREQ'(1);
  localparam logic [WWID-1:0] CREDIT_ONE = WWID'(1);

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   ptr_r, ptr_nxt_s;
  logic [WWID-1:0] credit_r, credit_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic            vld_r, vld_nxt_s;
  logic [IW-1:0]   idx_r, idx_nxt_s;

  logic            pick_any_s;
  logic [IW-1:0]   pick_idx_s;
  logic [WWID-1:0] weight_sel_s;
  logic [WWID-1:0] credit_load_s;
  logic            release_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_i),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign weight_sel_s  = weight_i[int'(pick_idx_s)*WWID +: WWID];
  assign credit_load_s = WWID'(clamp_weight(WMAX'(weight_sel_s)));
  // Quota exhausted on this beat, or the grantee withdrew its request.
  assign release_s     = !req_i[idx_r] || (ack_i && (credit_r == CREDIT_ONE));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s  = state_r;
    ptr_nxt_s    = ptr_r;
    credit_nxt_s = credit_r;
    gnt_nxt_s    = gnt_r;
    vld_nxt_s    = vld_r;
    idx_nxt_s    = idx_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s  = GRANT;
          credit_nxt_s = credit_load_s;
          gnt_nxt_s    = ONE_HOT << pick_idx_s;
          vld_nxt_s    = 1'b1;
          idx_nxt_s    = pick_idx_s;
        end else begin
          gnt_nxt_s = '0;
          vld_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s  = IDLE;
          credit_nxt_s = '0;
          gnt_nxt_s    = '0;
          vld_nxt_s    = 1'b0;
          ptr_nxt_s    = (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
        end else if (ack_i) begin
          credit_nxt_s = credit_r - CREDIT_ONE;
        end else begin
          credit_nxt_s = credit_r;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        credit_nxt_s = '0;
        gnt_nxt_s    = '0;
        vld_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      credit_r <= '0;
      gnt_r    <= '0;
      vld_r    <= 1'b0;
      idx_r    <= '0;
    end else begin
      state_r  <= state_nxt_s;
      ptr_r    <= ptr_nxt_s;
      credit_r <= credit_nxt_s;
      gnt_r    <= gnt_nxt_s;
      vld_r    <= vld_nxt_s;
      idx_r    <= idx_nxt_s;
    end
  end

  assign gnt_o     = gnt_r;
  assign gnt_vld_o = vld_r;
  assign gnt_idx_o = idx_r;

endmodule
